// File: rtl/led_blink_sched.sv
// led_blink_sched
//   Shares one board LED between N_REQ status requesters. The requester that wins
//   round-robin arbitration gets its blink code played to completion: N on/off blinks,
//   each half-period TICK_DIV clocks long, then GAP_TICKS dark half-periods.
// Ports
//   clk    board clock
//   rst_n  asynchronous active-low reset; aborts any sequence in progress
//   req    per-requester request level, sampled only while idle
//   code   blink count of requester i at [i*CNT_W +: CNT_W], latched at grant
//   grant  one-hot, 1-cycle pulse on the grant edge
//   done   one-hot, 1-cycle pulse when the owner's sequence finishes
//   busy   high from the grant edge through the done cycle
//   led    LED drive, active high
module led_blink_sched #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TICK_DIV  = 13500000,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] code,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   led
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;
  // Set on the grant of a zero-length code; the done pulse follows one cycle later.
  logic               zero_q, zero_d;

  logic               tick;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [CNT_W-1:0]   win_code;
  logic               granting;

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  // Round-robin search starting just after the last owner.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_p;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_p     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx   = (32'(last_q) + k) % N_REQ;
      idx_p = PTR_W'(idx);
      if (!win_found && req[idx_p]) begin
        win_found = 1'b1;
        win_idx   = idx_p;
      end
    end
  end

  assign win_code = code[32'(win_idx) * CNT_W +: CNT_W];
  assign granting = (state_q == StIdle) && !zero_q && win_found;

  // Divider restarts on grant so the first half-period is exactly TICK_DIV long.
  always_comb begin
    if (granting || tick) div_d = '0;
    else                  div_d = div_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    grant_d = '0;
    done_d  = '0;
    busy_d  = busy_q;
    led_d   = led_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        led_d = 1'b0;
        if (zero_q) begin
          // Finish a zero-length code; no arbitration this cycle.
          done_d = N_REQ'(1) << last_q;
          zero_d = 1'b0;
          busy_d = 1'b1;
        end else if (win_found) begin
          grant_d = N_REQ'(1) << win_idx;
          last_d  = win_idx;
          busy_d  = 1'b1;
          rem_d   = win_code;
          if (win_code != '0) begin
            led_d   = 1'b1;
            state_d = StOn;
          end else begin
            zero_d = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      StOn: begin
        if (tick) begin
          led_d   = 1'b0;
          rem_d   = rem_q - 1'b1;
          state_d = StOff;
        end
      end
      StOff: begin
        if (tick) begin
          if (rem_q != '0) begin
            led_d   = 1'b1;
            state_d = StOn;
          end else begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            // busy stays high through the done cycle and drops on the next edge if idle.
            done_d  = N_REQ'(1) << last_q;
            gap_d   = '0;
            state_d = StIdle;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= PTR_W'(N_REQ - 1);
      rem_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      zero_q  <= zero_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed bench for led_blink_sched with TICK_DIV=4, GAP_TICKS=2, N_REQ=4.
module tb_led_blink_sched;

  localparam int TD  = 4;
  localparam int GAP = 2;
  localparam int NR  = 4;
  localparam int CW  = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*CW-1:0]  code;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic              led;

  int n_chk = 0;
  int n_err = 0;

  led_blink_sched #(
    .N_REQ    (NR),
    .CNT_W    (CW),
    .TICK_DIV (TD),
    .GAP_TICKS(GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .code (code),
    .grant(grant),
    .done (done),
    .busy (busy),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " led"},   32'(led),   0);
    chk({tag, " grant"}, 32'(grant), 0);
    chk({tag, " done"},  32'(done),  0);
    chk({tag, " busy"},  32'(busy),  0);
  endtask

  // Called with the current cycle being the grant edge (t=0); returns in the done cycle.
  task automatic expect_seq(input int idx, input int n, input string tag);
    int t_end;
    t_end = (2 * n + GAP) * TD;
    for (int t = 0; t <= t_end; t++) begin
      if (t > 0) step();
      chk($sformatf("%s led t=%0d", tag, t), 32'(led),
          32'((t < 2 * n * TD) && ((t / TD) % 2 == 0)));
      chk($sformatf("%s grant t=%0d", tag, t), 32'(grant), (t == 0) ? (32'd1 << idx) : 32'd0);
      chk($sformatf("%s done t=%0d", tag, t), 32'(done), (t == t_end) ? (32'd1 << idx) : 32'd0);
      chk($sformatf("%s busy t=%0d", tag, t), 32'(busy), 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    code  = '0;

    // Power-on reset state.
    repeat (3) step();
    chk_all_zero("por");

    // Single requester 0 with code 3: done 32 cycles after grant.
    rst_n = 1'b1;
    req   = 4'b0001;
    code  = 16'h0003;
    step();
    req = '0;
    expect_seq(0, 3, "seq0c3");
    step();
    chk("seq0c3 busy after", 32'(busy), 0);
    chk("seq0c3 done after", 32'(done), 0);

    // Reset mid-run: outputs clear immediately and stay clear.
    req  = 4'b0010;
    code = 16'h0050;
    step();
    chk("mid grant", 32'(grant), 32'b0010);
    req = '0;
    step();
    step();
    chk("mid led on", 32'(led), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid rst now");
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all_zero($sformatf("mid rst hold %0d", i));
    end
    rst_n = 1'b1;
    step();
    chk("post rst busy", 32'(busy), 0);

    // All requesting, codes 1: order 0,1,2,3,0, each grant one cycle after done.
    req  = 4'b1111;
    code = 16'h1111;
    step();
    for (int g = 0; g < 5; g++) begin
      if (g == 4) req = '0;
      expect_seq(g % 4, 1, $sformatf("rr%0d", g));
      step();
    end
    chk("rr busy after", 32'(busy), 0);
    chk("rr grant after", 32'(grant), 0);

    // Zero-length code on requester 2.
    req  = 4'b0100;
    code = 16'h0000;
    step();
    chk("zero grant", 32'(grant), 32'b0100);
    chk("zero busy0", 32'(busy), 1);
    chk("zero led0", 32'(led), 0);
    chk("zero done0", 32'(done), 0);
    req = '0;
    step();
    chk("zero done", 32'(done), 32'b0100);
    chk("zero grant1", 32'(grant), 0);
    chk("zero busy1", 32'(busy), 1);
    chk("zero led1", 32'(led), 0);
    step();
    chk("zero busy2", 32'(busy), 0);
    chk("zero done2", 32'(done), 0);

    // Requester 1, code 2, reset during second ON, then a fresh full sequence.
    req  = 4'b0010;
    code = 16'h0020;
    step();
    chk("abort grant", 32'(grant), 32'b0010);
    for (int t = 1; t <= 9; t++) begin
      step();
      chk($sformatf("abort led t=%0d", t), 32'(led), 32'((t / TD) % 2 == 0));
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort rst now");
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all_zero($sformatf("abort rst hold %0d", i));
    end
    rst_n = 1'b1;
    step();
    req = '0;
    expect_seq(1, 2, "fresh1");
    step();
    chk("fresh1 busy after", 32'(busy), 0);

    // Req and code changed right after grant are ignored.
    req  = 4'b0001;
    code = 16'h0002;
    step();
    req  = '0;
    code = 16'h0007;
    expect_seq(0, 2, "latch0");
    step();
    chk("latch0 busy after", 32'(busy), 0);
    chk("latch0 led after", 32'(led), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
